// File: rtl/txd_quad.sv
// Four-byte serial transmitter: on send, shifts t1..t4 out as back-to-back
// UART frames (start, 8 data LSB first, optional parity, stop) at 8 ticks per bit.
module txd_quad #(
  parameter logic [15:0] BAUD_DIV = 16'h0516
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       send,
  input  logic [7:0] t1,
  input  logic [7:0] t2,
  input  logic [7:0] t3,
  input  logic [7:0] t4,
  input  logic       parity_en,
  input  logic       parity_kind,
  output logic       txd,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [15:0]     div_q, div_d;
  logic [2:0]      tick_cnt_q, tick_cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [1:0]      byte_idx_q, byte_idx_d;
  logic [3:0][7:0] bytes_q, bytes_d;
  logic            par_en_q, par_en_d;
  logic            par_kind_q, par_kind_d;
  logic            txd_q, txd_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic            tick;
  logic            last_tick;
  logic [7:0]      cur_byte_d;

  assign tick      = (state_q != S_IDLE) && (div_q == BAUD_DIV - 16'd1);
  assign last_tick = tick && (tick_cnt_q == 3'd7);

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    tick_cnt_d = tick_cnt_q;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    bytes_d    = bytes_q;
    par_en_d   = par_en_q;
    par_kind_d = par_kind_q;
    done_d     = 1'b0;

    if (state_q == S_IDLE) begin
      div_d      = 16'd0;
      tick_cnt_d = 3'd0;
      if (send) begin
        bytes_d    = {t4, t3, t2, t1};
        par_en_d   = parity_en;
        par_kind_d = parity_kind;
        bit_idx_d  = 3'd0;
        byte_idx_d = 2'd0;
        state_d    = S_START;
      end
    end else begin
      div_d = tick ? 16'd0 : div_q + 16'd1;
      if (tick) tick_cnt_d = tick_cnt_q + 3'd1;
    end

    // Every non-idle state ends on its 8th tick.
    if (last_tick) begin
      case (state_q)
        S_START: begin
          state_d   = S_DATA;
          bit_idx_d = 3'd0;
        end
        S_DATA: begin
          if (bit_idx_q == 3'd7) state_d = par_en_q ? S_PARITY : S_STOP;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end
        S_PARITY: state_d = S_STOP;
        S_STOP: begin
          if (byte_idx_q == 2'd3) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            byte_idx_d = byte_idx_q + 2'd1;
            bit_idx_d  = 3'd0;
            state_d    = S_START;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // txd is registered, so it is derived from the next-state values.
  always_comb begin
    cur_byte_d = bytes_d[byte_idx_d];
    busy_d     = (state_d != S_IDLE);
    case (state_d)
      S_START:  txd_d = 1'b0;
      S_DATA:   txd_d = cur_byte_d[bit_idx_d];
      S_PARITY: txd_d = par_kind_d ^ (^cur_byte_d);
      default:  txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      div_q      <= 16'd0;
      tick_cnt_q <= 3'd0;
      bit_idx_q  <= 3'd0;
      byte_idx_q <= 2'd0;
      bytes_q    <= '0;
      par_en_q   <= 1'b0;
      par_kind_q <= 1'b0;
      txd_q      <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      tick_cnt_q <= tick_cnt_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      bytes_q    <= bytes_d;
      par_en_q   <= par_en_d;
      par_kind_q <= par_kind_d;
      txd_q      <= txd_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign txd  = txd_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_txd_quad.sv
// Directed bench for txd_quad with BAUD_DIV=4 (32 clks per serial bit);
// checks txd/busy/done on every falling edge against hand-derived frames.
module tb_txd_quad;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       send;
  logic [7:0] t1, t2, t3, t4;
  logic       parity_en, parity_kind;
  logic       txd, busy, done;

  int total_cnt = 0;
  int bad_cnt   = 0;

  txd_quad #(.BAUD_DIV(16'd4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .send        (send),
    .t1          (t1),
    .t2          (t2),
    .t3          (t3),
    .t4          (t4),
    .parity_en   (parity_en),
    .parity_kind (parity_kind),
    .txd         (txd),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp, input int cyc);
    total_cnt++;
    assert (obs === exp) else begin
      bad_cnt++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  task automatic set_in(input logic [31:0] bytes, input logic pen, input logic pkind);
    {t4, t3, t2, t1} = bytes;
    parity_en   = pen;
    parity_kind = pkind;
  endtask

  // Starts at the first falling edge after acceptance (c=0) and ends on the
  // falling edge where done is expected high. bytes[7:0] is sent first.
  task automatic run_transfer(input logic [31:0] bytes, input logic [3:0] pbits,
                              input logic pen, input bit hold, input bit chg,
                              input string tag);
    int nb;
    int total;
    int f;
    int bi;
    logic [7:0] cur;
    logic exp_bit;
    nb    = pen ? 11 : 10;
    total = 4 * nb * 32;
    for (int c = 0; c <= total; c++) begin
      @(negedge clk);
      if (c == 1 && !hold) send = 1'b0;
      if (chg && c == 100) begin
        send = 1'b1;
        set_in(32'h1234_F00F, ~pen, 1'b0);
      end
      if (chg && c == 101) send = 1'b0;
      if (c < total) begin
        f   = c / (nb * 32);
        bi  = (c % (nb * 32)) / 32;
        cur = bytes[f*8 +: 8];
        if (bi == 0)                exp_bit = 1'b0;
        else if (bi <= 8)           exp_bit = cur[bi-1];
        else if (bi == 9 && nb == 11) exp_bit = pbits[f];
        else                        exp_bit = 1'b1;
        chk({tag, "_txd"},  txd,  exp_bit, c);
        chk({tag, "_busy"}, busy, 1'b1,    c);
        chk({tag, "_done"}, done, 1'b0,    c);
      end else begin
        chk({tag, "_done_end"}, done, 1'b1, c);
        chk({tag, "_busy_end"}, busy, 1'b0, c);
        chk({tag, "_txd_end"},  txd,  1'b1, c);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    send  = 1'b0;
    set_in(32'h0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk("rst_txd",  txd,  1'b1, 0);
    chk("rst_busy", busy, 1'b0, 0);
    chk("rst_done", done, 1'b0, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_busy", busy, 1'b0, 0);

    // No parity: 55, A3, 00, FF; done 1280 clks after acceptance.
    set_in(32'hFF00_A355, 1'b0, 1'b0);
    send = 1'b1;
    run_transfer(32'hFF00_A355, 4'b0000, 1'b0, 1'b0, 1'b0, "nopar");
    @(negedge clk);
    chk("nopar_done_1clk", done, 1'b0, 0);

    // Odd parity: 55(4 ones)->1, A3(4)->1, 00(0)->1, FF(8)->1.
    repeat (5) @(negedge clk);
    set_in(32'hFF00_A355, 1'b1, 1'b1);
    send = 1'b1;
    run_transfer(32'hFF00_A355, 4'b1111, 1'b1, 1'b0, 1'b0, "odd");

    // Even parity: 07(3 ones)->1, 03(2)->0, 00->0, FF->0.
    repeat (5) @(negedge clk);
    set_in(32'hFF00_0307, 1'b1, 1'b0);
    send = 1'b1;
    run_transfer(32'hFF00_0307, 4'b0001, 1'b1, 1'b0, 1'b0, "even");

    // Re-send and input changes at clk 100 must not disturb the transfer.
    repeat (5) @(negedge clk);
    set_in(32'h8142_C3E1, 1'b0, 1'b0);
    send = 1'b1;
    run_transfer(32'h8142_C3E1, 4'b0000, 1'b0, 1'b0, 1'b1, "ignore");
    repeat (40) @(negedge clk);
    chk("ignore_no_restart_busy", busy, 1'b0, 0);
    chk("ignore_no_restart_done", done, 1'b0, 0);

    // Reset during DATA of the second byte (bit 2).
    set_in(32'h0F0F_A55A, 1'b0, 1'b0);
    send = 1'b1;
    for (int c = 0; c <= 320 + 32*3 + 5; c++) begin
      @(negedge clk);
      if (c == 1) send = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1;
    chk("abort_txd",  txd,  1'b1, 0);
    chk("abort_busy", busy, 1'b0, 0);
    chk("abort_done", done, 1'b0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      chk("post_rst_done", done, 1'b0, c);
      chk("post_rst_busy", busy, 1'b0, c);
      chk("post_rst_txd",  txd,  1'b1, c);
    end
    set_in(32'h6699_3CC3, 1'b0, 1'b0);
    send = 1'b1;
    run_transfer(32'h6699_3CC3, 4'b0000, 1'b0, 1'b0, 1'b0, "after_rst");

    // Send held high: second transfer starts one clk after done.
    repeat (5) @(negedge clk);
    set_in(32'h0180_7E55, 1'b0, 1'b1);
    send = 1'b1;
    run_transfer(32'h0180_7E55, 4'b0000, 1'b0, 1'b1, 1'b0, "hold1");
    run_transfer(32'h0180_7E55, 4'b0000, 1'b0, 1'b0, 1'b0, "hold2");
    repeat (40) @(negedge clk);
    chk("hold_end_busy", busy, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
